semaforo_monitor: RTL and testbench

- Independent checker for the two-direction traffic-light controller. It observes the lamp outputs of both directions and flags illegal lamp encodings, conflicting right-of-way, illegal phase sequences and timing violations.
- Sits beside the controller inside the top-level wrapper, fed from the same lamp buses. Error status is visible on spare outputs for bring-up and for the cocotb bench.

---
 rtl/semaforo_monitor.sv | 112 +++++++++++
 tb/tb_semaforo_monitor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/semaforo_monitor.sv
// semaforo_monitor: watches both lamp buses and flags bad encodings, conflicts,
// illegal phase order and yellow/green dwell violations.
module semaforo_monitor #(
    parameter int MIN_GRN   = 5,
    parameter int YEL_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       tick,
    input  logic [2:0] lamps_a,
    input  logic [2:0] lamps_b,
    input  logic       clr,
    output logic       err,
    output logic [2:0] err_code,
    output logic [3:0] err_cnt,
    output logic [7:0] cycles_a
);
    typedef enum logic [1:0] {ACQ, RED, YEL, GRN} state_t;

    localparam logic [7:0] MG = 8'(MIN_GRN);
    localparam logic [7:0] YT = 8'(YEL_TICKS);

    state_t          r_st  [2];
    logic [7:0]      r_dw  [2];
    logic            r_unt [2];
    logic            r_err;
    logic [2:0]      r_code;
    logic [3:0]      r_cnt;
    logic [7:0]      r_cyc;

    logic [1:0][2:0] w_lamp;
    state_t          w_dec   [2];
    logic            w_chg   [2];
    logic            w_ok    [2];
    logic            w_timed [2];
    logic            w_unt   [2];
    logic [7:0]      w_dw    [2];
    logic [2:0]      w_ec    [2];
    logic            w_conf;
    logic            w_rg;
    logic            w_hit;
    logic [2:0]      w_code;

    function automatic logic [2:0] min_nz(input logic [2:0] a, input logic [2:0] b);
        return (a == 3'd0) ? b : (b == 3'd0) ? a : (a < b) ? a : b;
    endfunction

    assign w_lamp = {lamps_b, lamps_a};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_dec[i]   = w_lamp[i] == 3'b100 ? RED :
                         w_lamp[i] == 3'b010 ? YEL :
                         w_lamp[i] == 3'b001 ? GRN : ACQ;
            w_chg[i]   = w_dec[i] != r_st[i];
            w_ok[i]    = (r_st[i] == GRN && w_dec[i] == YEL) ||
                         (r_st[i] == YEL && w_dec[i] == RED) ||
                         (r_st[i] == RED && w_dec[i] == GRN);
            w_timed[i] = w_chg[i] && w_ok[i] && !r_unt[i];
            w_ec[i]    = w_dec[i] == ACQ                                  ? 3'd1 :
                         (w_chg[i] && r_st[i] != ACQ && !w_ok[i])         ? 3'd3 :
                         (w_timed[i] && r_st[i] == YEL && r_dw[i] != YT)  ? 3'd4 :
                         (w_timed[i] && r_st[i] == GRN && r_dw[i] < MG)   ? 3'd5 : 3'd0;
            // any phase not reached by a legal step (incl. first after ACQ) is untimed
            w_unt[i]   = w_chg[i] ? !w_ok[i] : r_unt[i];
            w_dw[i]    = w_chg[i] ? 8'd0 :
                         (tick && r_dw[i] != 8'hff) ? r_dw[i] + 8'd1 : r_dw[i];
        end
        w_conf = w_dec[0] != ACQ && w_dec[1] != ACQ && w_dec[0] != RED && w_dec[1] != RED;
        w_rg   = r_st[0] == RED && w_dec[0] == GRN;
        w_code = min_nz(min_nz(w_ec[0], w_ec[1]), w_conf ? 3'd2 : 3'd0);
        w_hit  = ena && w_code != 3'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_st[i]  <= ACQ;
                r_dw[i]  <= 8'd0;
                r_unt[i] <= 1'b1;
            end
            r_err  <= 1'b0;
            r_code <= 3'd0;
            r_cnt  <= 4'd0;
            r_cyc  <= 8'd0;
        end else begin
            if (ena) begin
                for (int i = 0; i < 2; i++) begin
                    r_st[i]  <= w_dec[i];
                    r_dw[i]  <= w_dw[i];
                    r_unt[i] <= w_unt[i];
                end
                if (w_rg) r_cyc <= r_cyc + 8'd1;
            end
            if (clr) begin
                r_err  <= w_hit;
                r_code <= w_hit ? w_code : 3'd0;
                r_cnt  <= w_hit ? 4'd1 : 4'd0;
            end else if (w_hit) begin
                r_err <= 1'b1;
                if (!r_err) r_code <= w_code;
                if (r_cnt != 4'hf) r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign err      = r_err;
    assign err_code = r_code;
    assign err_cnt  = r_cnt;
    assign cycles_a = r_cyc;
endmodule

// File: tb/tb_semaforo_monitor.sv
// tb_semaforo_monitor: directed phase sequences with a queue of expected
// {err, err_code, err_cnt, cycles_a} tuples checked one cycle after each sample.
module tb_semaforo_monitor;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, tick = 1'b0, clr = 1'b0;
    logic [2:0] la = R, lb = R;
    logic       err;
    logic [2:0] err_code;
    logic [3:0] err_cnt;
    logic [7:0] cycles_a;
    int         total = 0, bad = 0;
    logic [15:0] q[$];

    semaforo_monitor #(.MIN_GRN(5), .YEL_TICKS(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick),
        .lamps_a(la), .lamps_b(lb), .clr(clr),
        .err(err), .err_code(err_code), .err_cnt(err_cnt), .cycles_a(cycles_a)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [2:0] a, input logic [2:0] b, input logic t);
        la = a;
        lb = b;
        tick = t;
        @(negedge clk);
    endtask

    // hold a lamp pair so the dwell counter reaches n when the next phase starts
    task automatic phase(input logic [2:0] a, input logic [2:0] b, input int n);
        step(a, b, 1'b0);
        repeat (n) begin
            step(a, b, 1'b0);
            step(a, b, 1'b1);
        end
    endtask

    task automatic push(input logic e, input logic [2:0] c, input logic [3:0] n, input logic [7:0] cy);
        q.push_back({e, c, n, cy});
    endtask

    task automatic check(input string tag);
        logic [15:0] x;
        total++;
        assert (q.size() > 0) else begin
            bad++;
            $error("FAIL %s scoreboard empty got=%0d exp=1", tag, q.size());
        end
        if (q.size() > 0) begin
            x = q.pop_front();
            total++;
            assert (err === x[15]) else begin
                bad++;
                $error("FAIL %s err got=%0b exp=%0b", tag, err, x[15]);
            end
            total++;
            assert (err_code === x[14:12]) else begin
                bad++;
                $error("FAIL %s err_code got=%0d exp=%0d", tag, err_code, x[14:12]);
            end
            total++;
            assert (err_cnt === x[11:8]) else begin
                bad++;
                $error("FAIL %s err_cnt got=%0d exp=%0d", tag, err_cnt, x[11:8]);
            end
            total++;
            assert (cycles_a === x[7:0]) else begin
                bad++;
                $error("FAIL %s cycles_a got=%0d exp=%0d", tag, cycles_a, x[7:0]);
            end
        end
    endtask

    initial begin
        #3;
        push(0, 0, 0, 0);
        check("reset");
        @(negedge clk);
        rst_n = 1'b1;
        ena = 1'b1;

        // three clean cycles on A, first green untimed
        phase(G, R, 6);
        phase(Y, R, 2);
        for (int k = 1; k <= 3; k++) begin
            phase(R, R, 3);
            push(0, 0, 0, 8'(k));
            phase(G, R, 6);
            check("clean_cycle");
            phase(Y, R, 2);
        end

        // green too short
        phase(R, R, 3);
        phase(G, R, 3);
        push(1, 5, 1, 4);
        step(Y, R, 1'b0);
        check("grn_short");
        repeat (2) begin
            step(Y, R, 1'b0);
            step(Y, R, 1'b1);
        end
        phase(R, R, 3);

        // clear, conflict, then illegal encoding keeps the first code
        clr = 1'b1;
        push(0, 0, 0, 4);
        step(R, R, 1'b0);
        clr = 1'b0;
        check("clr");
        push(1, 2, 1, 5);
        step(G, G, 1'b0);
        check("conflict");
        push(1, 2, 2, 5);
        step(3'b011, G, 1'b0);
        check("enc_keeps_first");
        clr = 1'b1;
        push(0, 0, 0, 5);
        step(R, G, 1'b0);
        clr = 1'b0;
        check("clr_resync");
        repeat (6) begin
            step(R, G, 1'b0);
            step(R, G, 1'b1);
        end
        phase(R, Y, 2);
        phase(R, R, 3);
        push(0, 0, 0, 5);
        check("b_cycle_clean");

        // sequence error, then yellow held too long
        push(1, 3, 1, 5);
        step(Y, R, 1'b0);
        check("seq");
        clr = 1'b1;
        push(0, 0, 0, 5);
        step(Y, R, 1'b0);
        clr = 1'b0;
        check("clr_seq");
        phase(R, R, 3);
        phase(G, R, 6);
        phase(Y, R, 3);
        push(1, 4, 1, 6);
        step(R, R, 1'b0);
        check("yel_time");

        // clear on the same edge as a conflict: new error wins
        clr = 1'b1;
        push(1, 2, 1, 7);
        step(G, G, 1'b0);
        check("clr_vs_conflict");
        step(3'b111, 3'b111, 1'b0);
        push(0, 0, 0, 7);
        step(R, R, 1'b0);
        clr = 1'b0;
        check("clr_acq");

        // freeze mid-green: ticks and garbage ignored
        step(G, R, 1'b0);
        repeat (2) begin
            step(G, R, 1'b0);
            step(G, R, 1'b1);
        end
        ena = 1'b0;
        repeat (10) begin
            step(G, R, 1'b0);
            step(G, R, 1'b1);
        end
        step(3'b111, 3'b111, 1'b1);
        push(0, 0, 0, 8);
        check("freeze");
        ena = 1'b1;
        repeat (3) begin
            step(G, R, 1'b0);
            step(G, R, 1'b1);
        end
        push(0, 0, 0, 8);
        step(Y, R, 1'b0);
        check("grn_after_freeze");

        // async reset mid-yellow
        step(Y, R, 1'b1);
        rst_n = 1'b0;
        #2;
        push(0, 0, 0, 0);
        check("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(Y, R, 1'b0);
        repeat (5) begin
            step(Y, R, 1'b0);
            step(Y, R, 1'b1);
        end
        push(0, 0, 0, 0);
        step(R, R, 1'b0);
        check("untimed_after_rst");
        push(0, 0, 0, 1);
        step(G, R, 1'b0);
        check("cycles_after_rst");

        // error counter saturation
        repeat (17) step(3'b111, R, 1'b0);
        push(1, 1, 15, 1);
        check("cnt_saturate");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
